// File: rtl/lane_judge_core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_judge_core_pkg                                                      |
// | Shared types and default timing/scoring constants for the lane judge.    |
// | Contents: state_t (song FSM states), judge_kind_t (grade codes),         |
// |           default judgement windows (ms) and base points per grade.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package lane_judge_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    JK_PERFECT = 2'd0,
    JK_GOOD    = 2'd1,
    JK_MISS    = 2'd2
  } judge_kind_t;

  localparam int DEF_PERFECT_WIN = 40;
  localparam int DEF_GOOD_WIN    = 100;
  localparam int DEF_PTS_PERFECT = 300;
  localparam int DEF_PTS_GOOD    = 100;

endpackage
`default_nettype wire

// File: rtl/lane_judge_core_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_judge_core_fifo                                                     |
// | Per-lane pending-note FIFO (DEPTH x W). Head is visible combinationally. |
// | Ports: clk, rst_n (async, active-low), clr_i (sync flush), push_i/din_i, |
// |        pop_i, head_o, full_o, empty_o.                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module lane_judge_core_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q;
  logic [PTR_W:0] rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clr_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/lane_judge_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_judge_core                                                          |
// | N-lane note judge: buffers chart notes per lane, keeps song time, grades |
// | key presses against each lane head (PERFECT/GOOD/MISS), expires unhit    |
// | notes, and accumulates score / combo / max_combo.                        |
// | Ports: clk, rst_n (async, active-low), tick_ms_i, start_i, pause_i,      |
// |        song_end_i, keys_i, note_valid_i/note_ready_o/note_lane_i/        |
// |        note_time_i, song_time_o, judge_valid_o, judge_kind_o, score_o,   |
// |        combo_o, max_combo_o, state_o.                                    |
// | Build option: LANE_JUDGE_COMBO_BONUS_EN - each hit earns an extra        |
// |        base*min(combo,100)/100 points.                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module lane_judge_core
  import lane_judge_core_pkg::*;
#(
  parameter  int NUM_LANES   = 4,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int TIME_W      = 20,
  parameter  int PERFECT_WIN = DEF_PERFECT_WIN,
  parameter  int GOOD_WIN    = DEF_GOOD_WIN,
  parameter  int PTS_PERFECT = DEF_PTS_PERFECT,
  parameter  int PTS_GOOD    = DEF_PTS_GOOD,
  localparam int LANE_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_ms_i,
  input  logic                   start_i,
  input  logic                   pause_i,
  input  logic                   song_end_i,
  input  logic [NUM_LANES-1:0]   keys_i,
  input  logic                   note_valid_i,
  output logic                   note_ready_o,
  input  logic [LANE_W-1:0]      note_lane_i,
  input  logic [TIME_W-1:0]      note_time_i,
  output logic [TIME_W-1:0]      song_time_o,
  output logic [NUM_LANES-1:0]   judge_valid_o,
  output logic [2*NUM_LANES-1:0] judge_kind_o,
  output logic [31:0]            score_o,
  output logic [15:0]            combo_o,
  output logic [15:0]            max_combo_o,
  output logic [1:0]             state_o
);

  localparam logic [TIME_W:0] PERFECT_X = (TIME_W+1)'(PERFECT_WIN);
  localparam logic [TIME_W:0] GOOD_X    = (TIME_W+1)'(GOOD_WIN);
  localparam logic [31:0]     PTS_P32   = 32'(PTS_PERFECT);
  localparam logic [31:0]     PTS_G32   = 32'(PTS_GOOD);
  localparam logic [LANE_W:0] LANE_CNT  = (LANE_W+1)'(NUM_LANES);

  state_t                 state_q;
  logic [TIME_W-1:0]      song_time_q, song_time_d;
  logic [NUM_LANES-1:0]   keys_prev_q;
  logic [NUM_LANES-1:0]   judge_valid_q;
  logic [2*NUM_LANES-1:0] judge_kind_q;
  logic [31:0]            score_q, score_d;
  logic [15:0]            combo_q, combo_d, max_combo_q, max_combo_d;

  logic                   w_playing, w_live, w_judge_en, w_lane_ok;
  logic [NUM_LANES-1:0]   w_press, w_full, w_hit, w_miss, w_pop;
  logic [2*NUM_LANES-1:0] w_kind;
  logic [31:0]            w_pts [NUM_LANES];
  logic [16:0]            w_hits, w_combo_sum;
  logic [32:0]            w_pts_sum, w_score_sum;

  assign w_playing  = (state_q == ST_PLAYING);
  assign w_live     = w_playing || (state_q == ST_PAUSED);
  // A start pulse flushes everything, so nothing is judged or accepted that cycle.
  assign w_judge_en = w_playing && !start_i;
  assign w_press    = keys_i & ~keys_prev_q;
  assign w_lane_ok  = ({1'b0, note_lane_i} < LANE_CNT);
  // Notes are only taken while a song is live (PLAYING or PAUSED).
  assign note_ready_o = w_live && !start_i && w_lane_ok && !w_full[note_lane_i];

`ifdef LANE_JUDGE_COMBO_BONUS_EN
  logic [31:0] w_bonus_pct;
  assign w_bonus_pct = (combo_q > 16'd100) ? 32'd100 : {16'd0, combo_q};
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [TIME_W-1:0] w_head;
    logic              w_empty, w_push, w_expire, w_in_perf, w_perfect, w_good;
    logic [TIME_W:0]   w_head_x, w_time_x, w_limit, w_delta;
    logic [31:0]       w_base;

    assign w_push = note_valid_i && note_ready_o && (note_lane_i == LANE_W'(g));

    lane_judge_core_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (TIME_W)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (start_i),
      .push_i  (w_push),
      .din_i   (note_time_i),
      .pop_i   (w_pop[g]),
      .head_o  (w_head),
      .full_o  (w_full[g]),
      .empty_o (w_empty)
    );

    // One extra bit so neither the window limit nor the distance can wrap.
    assign w_head_x  = {1'b0, w_head};
    assign w_time_x  = {1'b0, song_time_q};
    assign w_limit   = w_head_x + GOOD_X;
    assign w_delta   = (w_time_x >= w_head_x) ? (w_time_x - w_head_x) : (w_head_x - w_time_x);

    // Expiry outranks a press in the same cycle; the press is simply dropped.
    assign w_expire  = w_judge_en && !w_empty && (w_time_x > w_limit);
    assign w_in_perf = (w_delta <= PERFECT_X);
    assign w_perfect = w_judge_en && !w_empty && !w_expire && w_press[g] && w_in_perf;
    assign w_good    = w_judge_en && !w_empty && !w_expire && w_press[g] && !w_in_perf &&
                       (w_delta <= GOOD_X);

    assign w_miss[g] = w_expire;
    assign w_hit[g]  = w_perfect || w_good;
    assign w_pop[g]  = w_expire || w_perfect || w_good;
    assign w_kind[2*g +: 2] = w_expire ? JK_MISS : (w_good ? JK_GOOD : JK_PERFECT);
    assign w_base    = w_perfect ? PTS_P32 : PTS_G32;

`ifdef LANE_JUDGE_COMBO_BONUS_EN
    assign w_pts[g] = w_hit[g] ? (w_base + (w_base * w_bonus_pct) / 32'd100) : 32'd0;
`else
    assign w_pts[g] = w_hit[g] ? w_base : 32'd0;
`endif
  end

  always_comb begin
    w_hits    = '0;
    w_pts_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_hits    = w_hits + 17'(w_hit[i]);
      w_pts_sum = w_pts_sum + {1'b0, w_pts[i]};
    end
  end

  // Any miss this cycle restarts the combo at this cycle's hit count.
  assign w_combo_sum = {1'b0, combo_q} + w_hits;
  assign combo_d     = (|w_miss) ? w_hits[15:0] :
                       (w_combo_sum[16] ? 16'hFFFF : w_combo_sum[15:0]);
  assign max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  assign w_score_sum = {1'b0, score_q} + w_pts_sum;
  assign score_d     = w_score_sum[32] ? 32'hFFFF_FFFF : w_score_sum[31:0];
  assign song_time_d = (w_playing && tick_ms_i && !(&song_time_q)) ?
                       song_time_q + TIME_W'(1) : song_time_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      song_time_q   <= '0;
      keys_prev_q   <= '0;
      judge_valid_q <= '0;
      judge_kind_q  <= '0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
    end else begin
      keys_prev_q <= keys_i;
      if (start_i) begin
        state_q       <= ST_PLAYING;
        song_time_q   <= '0;
        judge_valid_q <= '0;
        judge_kind_q  <= '0;
        score_q       <= '0;
        combo_q       <= '0;
        max_combo_q   <= '0;
      end else begin
        song_time_q   <= song_time_d;
        judge_valid_q <= w_pop;
        judge_kind_q  <= w_kind;
        score_q       <= score_d;
        combo_q       <= combo_d;
        max_combo_q   <= max_combo_d;
        case (state_q)
          ST_PLAYING: begin
            if (song_end_i)   state_q <= ST_DONE;
            else if (pause_i) state_q <= ST_PAUSED;
          end
          ST_PAUSED: begin
            if (song_end_i)    state_q <= ST_DONE;
            else if (!pause_i) state_q <= ST_PLAYING;
          end
          default: ;
        endcase
      end
    end
  end

  assign song_time_o   = song_time_q;
  assign judge_valid_o = judge_valid_q;
  assign judge_kind_o  = judge_kind_q;
  assign score_o       = score_q;
  assign combo_o       = combo_q;
  assign max_combo_o   = max_combo_q;
  assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_judge_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lane_judge_core                                                       |
// | Self-checking bench: directed song scenarios followed by randomized      |
// | play, all compared against a queue-based reference model.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_lane_judge_core;

  localparam int NL = 4;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_ms = 1'b0, start = 1'b0, pause = 1'b0, song_end = 1'b0;
  logic [NL-1:0] keys = '0;
  logic          note_valid = 1'b0;
  logic [1:0]    note_lane = '0;
  logic [TW-1:0] note_time = '0;
  logic          note_ready;
  logic [TW-1:0] song_time;
  logic [NL-1:0] judge_valid;
  logic [2*NL-1:0] judge_kind;
  logic [31:0]   score;
  logic [15:0]   combo, max_combo;
  logic [1:0]    state;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: song state as plain integers, one queue of note times per lane.
  int            m_q [NL][$];
  int            m_state, m_time, m_combo, m_max;
  longint        m_score;
  logic [NL-1:0] m_prev, m_jv;
  logic [2*NL-1:0] m_jk;

  lane_judge_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_ms_i     (tick_ms),
    .start_i       (start),
    .pause_i       (pause),
    .song_end_i    (song_end),
    .keys_i        (keys),
    .note_valid_i  (note_valid),
    .note_ready_o  (note_ready),
    .note_lane_i   (note_lane),
    .note_time_i   (note_time),
    .song_time_o   (song_time),
    .judge_valid_o (judge_valid),
    .judge_kind_o  (judge_kind),
    .score_o       (score),
    .combo_o       (combo),
    .max_combo_o   (max_combo),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint hit_pts(input int base, input int cb);
`ifdef LANE_JUDGE_COMBO_BONUS_EN
    return base + (base * ((cb > 100) ? 100 : cb)) / 100;
`else
    return base;
`endif
  endfunction

  function automatic bit exp_ready();
    return (m_state == 1 || m_state == 2) && !start && (m_q[note_lane].size() < 8);
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) m_q[l].delete();
    m_state = 0; m_time = 0; m_combo = 0; m_max = 0; m_score = 0;
    m_prev = '0; m_jv = '0; m_jk = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [NL-1:0]   press, jv;
    logic [2*NL-1:0] jk;
    bit     en, miss, rdy;
    int     hits, h, d, nc;
    longint add;
    press = keys & ~m_prev;
    rdy   = exp_ready();
    en    = (m_state == 1) && !start;
    jv = '0; jk = '0; miss = 0; hits = 0; add = 0;
    for (int l = 0; l < NL; l++) begin
      if (en && m_q[l].size() > 0) begin
        h = m_q[l][0];
        d = (m_time > h) ? m_time - h : h - m_time;
        if (m_time > h + 100) begin
          miss = 1; jv[l] = 1'b1; jk[2*l +: 2] = 2'd2; void'(m_q[l].pop_front());
        end else if (press[l] && d <= 40) begin
          hits++; add += hit_pts(300, m_combo); jv[l] = 1'b1; void'(m_q[l].pop_front());
        end else if (press[l] && d <= 100) begin
          hits++; add += hit_pts(100, m_combo); jv[l] = 1'b1; jk[2*l +: 2] = 2'd1;
          void'(m_q[l].pop_front());
        end
      end
    end
    if (rdy && note_valid) m_q[note_lane].push_back(int'(note_time));
    nc = miss ? hits : ((m_combo + hits > 65535) ? 65535 : m_combo + hits);
    if (start) begin
      for (int l = 0; l < NL; l++) m_q[l].delete();
      m_state = 1; m_time = 0; m_score = 0; m_combo = 0; m_max = 0; m_jv = '0; m_jk = '0;
    end else begin
      m_jv = jv; m_jk = jk; m_combo = nc;
      if (nc > m_max) m_max = nc;
      m_score = (m_score + add > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_score + add;
      if (m_state == 1 && tick_ms && m_time < (1 << TW) - 1) m_time++;
      if ((m_state == 1 || m_state == 2) && song_end) m_state = 3;
      else if (m_state == 1 && pause)  m_state = 2;
      else if (m_state == 2 && !pause) m_state = 1;
    end
    m_prev = keys;
  endtask

  // Called at a falling edge with inputs applied; ends at the next falling edge.
  task automatic step();
    #1;
    check_eq("note_ready", note_ready, exp_ready());
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("song_time", song_time, m_time);
    check_eq("state", state, m_state);
    check_eq("score", score, m_score);
    check_eq("combo", combo, m_combo);
    check_eq("max_combo", max_combo, m_max);
    check_eq("judge_valid", judge_valid, m_jv);
    check_eq("judge_kind", judge_kind, m_jk);
    start = 1'b0; song_end = 1'b0; note_valid = 1'b0;
  endtask

  task automatic push_note(input int lane, input int t);
    note_valid = 1'b1; note_lane = 2'(lane); note_time = TW'(t);
    step();
  endtask

  task automatic run_to(input int t);
    int n = 0;
    tick_ms = 1'b1;
    while (m_time != t && n < 20000) begin step(); n++; end
    if (m_time != t) check_eq("run_to_timeout", 64'(m_time), 64'(t));
  endtask

  task automatic press_at(input logic [NL-1:0] mask, input int t);
    run_to(t);
    keys = mask;
    step();
    keys = '0;
  endtask

  task automatic do_reset();
    keys = '0; pause = 1'b0; start = 1'b0; song_end = 1'b0; note_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_score", score, 0);
    check_eq("rst_combo", combo, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_ready", note_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("idle_ready", note_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_song_time", song_time, 0);
    check_eq("reset_max_combo", max_combo, 0);
    check_eq("reset_judge_valid", judge_valid, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_ready0", note_ready, 0);

    // Directed song.
    tick_ms = 1'b1;
    start = 1'b1; step();
    check_eq("start_state", state, 1);
    push_note(0, 1000); push_note(0, 1000); push_note(0, 1150); push_note(0, 1160);
    push_note(0, 1170); push_note(0, 1211); push_note(1, 500);
    push_note(2, 1150); push_note(3, 1110);

    run_to(601); step();
    check_eq("miss_valid", judge_valid[1], 1);
    check_eq("miss_kind", judge_kind[3:2], 2);
    check_eq("miss_combo", combo, 0);

    press_at(4'b0001, 1020);
    check_eq("perfect_kind", judge_kind[1:0], 0);
    check_eq("perfect_combo", combo, 1);
`ifndef LANE_JUDGE_COMBO_BONUS_EN
    check_eq("perfect_score", score, 300);
`endif
    press_at(4'b0001, 1090);
    check_eq("good_kind", judge_kind[1:0], 1);
    check_eq("good_combo", combo, 2);
`ifndef LANE_JUDGE_COMBO_BONUS_EN
    check_eq("good_score", score, 400);
`endif
    press_at(4'b0001, 1150); press_at(4'b0001, 1160); press_at(4'b0001, 1170);
    check_eq("combo5", combo, 5);
    press_at(4'b0101, 1211);
    check_eq("multi_valid", judge_valid, 4'b1101);
    check_eq("multi_kind", judge_kind, 8'b10_01_00_00);
    check_eq("multi_combo", combo, 2);
    check_eq("multi_max", max_combo, 5);
`ifndef LANE_JUDGE_COMBO_BONUS_EN
    check_eq("multi_score", score, 1700);
`endif

    // Pause: time frozen, presses ignored, FIFO fill while paused.
    pause = 1'b1; step();
    check_eq("paused_state", state, 2);
    for (int i = 0; i < 8; i++) push_note(2, 5000 + i);
    repeat (3) step();
    check_eq("pause_hold", song_time, 1213);
    note_lane = 2'd2; #1;
    check_eq("full_ready_l2", note_ready, 0);
    note_lane = 2'd0; #1;
    check_eq("ready_l0", note_ready, 1);
    keys = 4'b0100; step(); keys = '0; step();
    check_eq("pause_no_judge", judge_valid, 0);
    pause = 1'b0;
    start = 1'b1; step();
    check_eq("restart_max", max_combo, 0);

    // Randomized play.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int r;
      tick_ms = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NL; l++) if ($urandom_range(0, 5) == 0) keys[l] = ~keys[l];
      if ($urandom_range(0, 150) == 0) pause = ~pause;
      note_valid = ($urandom_range(0, 2) == 0);
      note_lane  = 2'($urandom_range(0, NL - 1));
      r = m_time + int'($urandom_range(0, 250)) - 40;
      note_time  = TW'((r < 0) ? 0 : r);
      r = int'($urandom_range(0, 999));
      if ((m_state == 0 || m_state == 3) && $urandom_range(0, 19) == 0) start = 1'b1;
      else if (r < 2) start = 1'b1;
      else if (r < 4) song_end = 1'b1;
      if (r == 4) do_reset();
      else step();
    end

    // Reset in the middle of a song.
    start = 1'b1; step();
    push_note(0, 20);
    press_at(4'b0001, 20);
    do_reset();
    check_eq("midreset_state", state, 0);
    check_eq("midreset_score", score, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
